// File: rtl/cordic_arbiter.sv
// cordic_arbiter: shares one multi-cycle CORDIC core among NUM_REQ requesters.
// A round-robin grant in IDLE hands one angle to the core. The FSM then waits
// for core_done, or for the timeout. It sends one response strobe back to the
// owner and returns to IDLE. Only one job is outstanding at any time.
module cordic_arbiter #(
  parameter int NUM_REQ          = 4,
  parameter int FLOAT_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES   = 1000,
  parameter int TIMEOUT_WIDTH    = 10
) (
  input  logic                                  clk,
  input  logic                                  rst,
  // requester side
  input  logic [NUM_REQ-1:0]                    req_valid,
  input  logic [NUM_REQ*FLOAT_DATA_WIDTH-1:0]   req_angle,
  output logic [NUM_REQ-1:0]                    req_ready,
  output logic [NUM_REQ-1:0]                    rsp_valid,
  output logic [FLOAT_DATA_WIDTH-1:0]           rsp_result,
  output logic                                  rsp_error,
  // core side
  output logic                                  core_start,
  output logic [FLOAT_DATA_WIDTH-1:0]           core_angle,
  output logic                                  core_rst,
  input  logic [FLOAT_DATA_WIDTH-1:0]           core_result,
  input  logic                                  core_done,
  // status
  output logic                                  busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESPOND,
    RECOVER
  } state_t;

  // Elaboration-time parameter sanity checks.
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("cordic_arbiter: NUM_REQ must be in 2..8");
  end
  if ((2 ** TIMEOUT_WIDTH) < TIMEOUT_CYCLES) begin : g_bad_timeout_width
    $error("cordic_arbiter: TIMEOUT_WIDTH too narrow for TIMEOUT_CYCLES");
  end

  state_t                        state_q, state_d;
  logic [IDX_W-1:0]              last_grant_q;
  logic [IDX_W-1:0]              owner_id_q;
  logic [FLOAT_DATA_WIDTH-1:0]   result_q;
  logic [TIMEOUT_WIDTH-1:0]      count_q;

  logic [FLOAT_DATA_WIDTH-1:0]   angle_arr [NUM_REQ];
  logic                          grant_found;
  logic [IDX_W-1:0]              grant_idx;
  logic [IDX_W-1:0]              cand;
  logic [NUM_REQ-1:0]            owner_onehot;
  logic                          timeout_hit;

  assign timeout_hit = (count_q == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));

  // Unpack the flat angle bus so the granted slice can be selected by index.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      angle_arr[i] = req_angle[i*FLOAT_DATA_WIDTH +: FLOAT_DATA_WIDTH];
    end
  end

  // Round-robin search: the first valid requester after last_grant, wrapping.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write;
    // a path that leaves one unassigned would infer a latch.
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_grant_q) + k) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Decode the current owner into the one-hot response strobe pattern.
  always_comb begin
    owner_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      owner_onehot[i] = (owner_id_q == IDX_W'(i));
    end
  end

  // State register; reset forces IDLE asynchronously, aborting any job.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples pre-edge values, independent of statement order.
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode. The IDLE grant is gated by rst so that
  // req_ready stays low while reset is held.
  always_comb begin
    state_d    = state_q;
    req_ready  = '0;
    rsp_valid  = '0;
    rsp_result = '0;
    rsp_error  = 1'b0;
    core_start = 1'b0;
    core_rst   = 1'b0;
    busy       = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (grant_found && !rst) begin
          req_ready[grant_idx] = 1'b1;
          state_d              = ISSUE;
        end
      end
      ISSUE: begin
        core_start = 1'b1;
        state_d    = WAIT;
      end
      WAIT: begin
        // A done on the expiry cycle still counts as a normal completion.
        if (core_done) begin
          state_d = RESPOND;
        end else if (timeout_hit) begin
          state_d = RECOVER;
        end
      end
      RESPOND: begin
        rsp_valid  = owner_onehot;
        rsp_result = result_q;
        state_d    = IDLE;
      end
      RECOVER: begin
        core_rst  = 1'b1;
        rsp_valid = owner_onehot;
        rsp_error = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Job datapath. It captures the grant, runs the timeout counter, latches the
  // result and advances the round-robin pointer when a job ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      owner_id_q   <= '0;
      core_angle   <= '0;
      result_q     <= '0;
      count_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_found) begin
            owner_id_q <= grant_idx;
            core_angle <= angle_arr[grant_idx];
          end
        end
        ISSUE: begin
          count_q <= '0;
        end
        WAIT: begin
          count_q <= count_q + TIMEOUT_WIDTH'(1);
          if (core_done) begin
            result_q <= core_result;
          end
        end
        RESPOND, RECOVER: begin
          last_grant_q <= owner_id_q;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_arbiter.sv
// tb_cordic_arbiter: directed scoreboard bench for cordic_arbiter.
// Stimulus pushes the expected grant, core job and response into queues. A
// core model and a monitor pop and compare them as the DUT produces events.
module tb_cordic_arbiter;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int TC  = 16;
  localparam int TW  = 10;

  typedef struct {
    int          lat;    // core_start -> core_done distance; 0 = never done
    logic [31:0] res;
    logic [31:0] angle;
  } job_t;

  typedef struct {
    int          idx;
    logic [31:0] res;
    logic        err;
    int          delta;  // cycles from handshake to the response strobe
  } rsp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_angle;
  logic [N-1:0]     req_ready;
  logic [N-1:0]     rsp_valid;
  logic [W-1:0]     rsp_result;
  logic             rsp_error;
  logic             core_start;
  logic [W-1:0]     core_angle;
  logic             core_rst;
  logic [W-1:0]     core_result;
  logic             core_done;
  logic             busy;

  logic             done_model;
  logic             stray_done;
  assign core_done = done_model | stray_done;

  int   cyc = 0;
  int   hs_count = 0;
  int   hs_cycle = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  int   grant_q [$];
  job_t model_q [$];
  rsp_t rsp_q [$];

  logic [31:0] angles [N];

  cordic_arbiter #(
    .NUM_REQ(N), .FLOAT_DATA_WIDTH(W), .TIMEOUT_CYCLES(TC), .TIMEOUT_WIDTH(TW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_angle(req_angle), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_error(rsp_error),
    .core_start(core_start), .core_angle(core_angle), .core_rst(core_rst),
    .core_result(core_result), .core_done(core_done), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // kind: 0 = normal response, 1 = timeout abort, 2 = no response (reset)
  task automatic expect_job(input int idx, input int lat, input logic [31:0] res, input int kind);
    job_t j;
    rsp_t r;
    grant_q.push_back(idx);
    j.lat = lat; j.res = res; j.angle = angles[idx];
    model_q.push_back(j);
    if (kind != 2) begin
      r.idx   = idx;
      r.res   = (kind == 1) ? 32'h0 : res;
      r.err   = (kind == 1);
      r.delta = (kind == 1) ? TC + 2 : lat + 2;
      rsp_q.push_back(r);
    end
  endtask

  task automatic wait_hs(input int target);
    int n = 0;
    while (hs_count < target && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    if (hs_count < target) check("handshake_timeout", 64'(hs_count), 64'(target));
  endtask

  task automatic wait_drain();
    int n = 0;
    while (rsp_q.size() != 0 && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    if (rsp_q.size() != 0) check("response_timeout", 64'(rsp_q.size()), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"},  req_ready,  0);
    check({tag, "_rsp_valid"},  rsp_valid,  0);
    check({tag, "_rsp_result"}, rsp_result, 0);
    check({tag, "_rsp_error"},  rsp_error,  0);
    check({tag, "_core_start"}, core_start, 0);
    check({tag, "_core_rst"},   core_rst,   0);
    check({tag, "_core_angle"}, core_angle, 0);
    check({tag, "_busy"},       busy,       0);
  endtask

  // Core model: on core_start, check the operand and pulse done after lat cycles.
  initial begin : core_model
    job_t m;
    done_model  = 1'b0;
    core_result = 32'hDEADBEEF;
    forever begin
      @(negedge clk);
      if (core_start) begin
        if (model_q.size() == 0) begin
          check("unexpected_core_start", 1, 0);
        end else begin
          m = model_q.pop_front();
          check("core_angle", core_angle, m.angle);
          if (m.lat > 0) begin
            repeat (m.lat) @(posedge clk);
            #1 done_model = 1'b1;
            core_result = m.res;
            @(posedge clk);
            #1 done_model = 1'b0;
            core_result = 32'hDEADBEEF;
          end
        end
      end
    end
  end

  // Monitor: invariants every cycle, plus grant and response scoreboarding.
  initial begin : monitor
    int   g;
    rsp_t r;
    forever begin
      @(negedge clk);
      check("ready_onehot0", $onehot0(req_ready), 1);
      check("ready_only_in_idle", busy && (req_ready != 0), 0);
      check("core_rst_only_on_abort", core_rst && !(rsp_error && (rsp_valid != 0)), 0);
      if ((req_valid & req_ready) != 0) begin
        if (grant_q.size() == 0) begin
          check("unexpected_grant", req_ready, 0);
        end else begin
          g = grant_q.pop_front();
          check("grant", req_ready, 64'(4'b0001 << g));
        end
        hs_cycle = cyc;
        hs_count++;
      end
      if (rsp_valid != 0) begin
        if (rsp_q.size() == 0) begin
          check("unexpected_rsp", rsp_valid, 0);
        end else begin
          r = rsp_q.pop_front();
          check("rsp_valid", rsp_valid, 64'(4'b0001 << r.idx));
          check("rsp_result", rsp_result, r.res);
          check("rsp_error", rsp_error, r.err);
          check("core_rst", core_rst, r.err);
          check("rsp_latency", 64'(cyc - hs_cycle), 64'(r.delta));
        end
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1);
  end

  // Directed stimulus.
  initial begin
    angles[0] = 32'h3F000000;
    angles[1] = 32'h3F800000;
    angles[2] = 32'h3FC90FDB;
    angles[3] = 32'h40490FDB;
    req_angle  = {angles[3], angles[2], angles[1], angles[0]};
    rst        = 1'b1;
    req_valid  = 4'hF;
    stray_done = 1'b1;

    // Reset state: all outputs low even with requests and done asserted.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst        = 1'b0;
    req_valid  = '0;
    stray_done = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Single request: done 8 cycles after start, response at handshake+10.
    expect_job(0, 8, 32'h3EF57744, 0);
    req_valid = 4'b0001;
    wait_hs(1);
    @(posedge clk); #1 req_valid = '0;
    wait_drain();
    repeat (2) @(posedge clk); #1;

    // Timeout: no done ever, so the abort comes TC+2 cycles after the handshake.
    expect_job(2, 0, 32'h0, 1);
    req_valid = 4'b0100;
    wait_hs(2);
    @(posedge clk); #1 req_valid = '0;
    wait_drain();
    repeat (2) @(posedge clk); #1;

    // The next job after an abort proceeds normally.
    expect_job(1, 3, 32'h3F3504F3, 0);
    req_valid = 4'b0010;
    wait_hs(3);
    @(posedge clk); #1 req_valid = '0;
    wait_drain();
    repeat (2) @(posedge clk); #1;

    // Coincidence: done on the last counted WAIT cycle still wins.
    expect_job(3, TC, 32'h3F7FFFFF, 0);
    req_valid = 4'b1000;
    wait_hs(4);
    @(posedge clk); #1 req_valid = '0;
    wait_drain();
    repeat (2) @(posedge clk); #1;

    // Stray done in IDLE: no state change, no response.
    stray_done = 1'b1;
    @(posedge clk); #1 stray_done = 1'b0;
    repeat (2) @(negedge clk);
    check("stray_idle_busy", busy, 0);
    @(posedge clk); #1;

    // Stray done in ISSUE: ignored; the real done at start+5 gives the result.
    expect_job(0, 5, 32'h3E800000, 0);
    req_valid = 4'b0001;
    wait_hs(5);
    @(posedge clk); #1;
    req_valid  = '0;
    stray_done = 1'b1;
    @(posedge clk); #1 stray_done = 1'b0;
    wait_drain();
    repeat (2) @(posedge clk); #1;

    // Reset three cycles after core_start: abort silently, outputs low.
    expect_job(2, 0, 32'h0, 2);
    req_valid = 4'b0100;
    wait_hs(6);
    @(posedge clk); #1 req_valid = '0;
    repeat (3) @(posedge clk); #1;
    rst       = 1'b1;
    req_valid = 4'hF;
    // Fairness after reset: grant order 0,1,2,3,0 with all requests held.
    expect_job(0, 2, 32'h10000000, 0);
    expect_job(1, 2, 32'h10000001, 0);
    expect_job(2, 2, 32'h10000002, 0);
    expect_job(3, 2, 32'h10000003, 0);
    expect_job(0, 2, 32'h10000004, 0);
    @(negedge clk);
    check_all_zero("mid_job_reset");
    @(posedge clk); #1 rst = 1'b0;
    wait_hs(11);
    @(posedge clk); #1 req_valid = '0;
    wait_drain();
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("grants_pending", 64'(grant_q.size()), 0);
    check("jobs_pending", 64'(model_q.size()), 0);
    check("final_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
